// File: rtl/adder_accumulator_pkg.sv
// Shared definitions for the burst accumulator: FSM encodings and datapath width.
package adder_accumulator_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/fourBitFullAdder.sv
// Combinational 4-bit adder with carry-in; the datapath reused by the accumulator.
module fourBitFullAdder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/adder_accumulator.sv
// Multi-operand burst summing unit: accepts 4-bit operands over valid/ready,
// accumulates them through one fourBitFullAdder, and presents the burst result.
//
//   state | meaning
//   IDLE  | empty, waiting for the first operand of a burst
//   ACCUM | burst in progress, accepting further operands
//   DONE  | result held on out_*, waiting for out_ready
module adder_accumulator
    import adder_accumulator_pkg::*;
#(
    parameter int MAX_OPS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             use_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [WIDTH-1:0] out_count
);

    localparam logic [WIDTH-1:0] MAX_OPS_C = WIDTH'(MAX_OPS);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] count_q, count_d;

    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             cin;
    logic             accept;
    logic [WIDTH-1:0] count_inc;

    assign cin       = use_carry & carry_q;
    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign count_inc = count_q + 1'b1;

    fourBitFullAdder u_adder (
        .a    (acc_q),
        .b    (in_data),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    // IDLE and ACCUM share one update: in IDLE the registers are all zero,
    // so sticky|cout and count+1 reduce to the first-operand values.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        sticky_d = sticky_q;
        count_d  = count_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d    = sum;
                    carry_d  = cout;
                    sticky_d = sticky_q | cout;
                    count_d  = count_inc;
                    state_d  = (in_last || count_inc == MAX_OPS_C) ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d  = IDLE;
                    acc_d    = '0;
                    carry_d  = 1'b0;
                    sticky_d = 1'b0;
                    count_d  = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                acc_d    = '0;
                carry_d  = 1'b0;
                sticky_d = 1'b0;
                count_d  = '0;
            end
        endcase
    end

    assign out_sum   = acc_q;
    assign out_carry = sticky_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed bench for adder_accumulator: bursts, wrap, chained carry, cap,
// backpressure and mid-burst reset, with hand-computed expectations.
module tb_adder_accumulator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       use_carry;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_carry;
    logic [3:0] out_count;

    int total = 0;
    int bad   = 0;

    adder_accumulator #(.MAX_OPS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .use_carry (use_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic push(input logic [3:0] d, input logic l, input logic uc);
        int w;
        w = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        use_carry = uc;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk("accept_timeout", 4'd1, 4'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = 4'hA;
        in_last   = 1'b0;
        use_carry = 1'b0;
    endtask

    task automatic finish_burst(input string tag, input logic [3:0] es,
                                input logic ec, input logic [3:0] en);
        chk({tag, "_out_valid"}, {3'b0, out_valid}, 4'd1);
        chk({tag, "_in_ready"},  {3'b0, in_ready},  4'd0);
        chk({tag, "_sum"},       out_sum,           es);
        chk({tag, "_carry"},     {3'b0, out_carry}, {3'b0, ec});
        chk({tag, "_count"},     out_count,         en);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_valid"}, {3'b0, out_valid}, 4'd0);
        chk({tag, "_idle_ready"}, {3'b0, in_ready},  4'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_last   = 1'b0;
        use_carry = 1'b0;
        out_ready = 1'b0;

        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = ~in_valid;
            in_data   = 4'(i * 5 + 3);
            in_last   = ~in_last;
            use_carry = ~use_carry;
            out_ready = ~out_ready;
        end
        chk("rst_out_valid", {3'b0, out_valid}, 4'd0);
        chk("rst_out_sum",   out_sum,           4'd0);
        chk("rst_out_carry", {3'b0, out_carry}, 4'd0);
        chk("rst_out_count", out_count,         4'd0);
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        use_carry = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready",  {3'b0, in_ready},  4'd1);
        chk("post_rst_out_valid", {3'b0, out_valid}, 4'd0);

        // 3 + 4
        push(4'd3, 1'b0, 1'b0);
        chk("b1_mid_out_valid", {3'b0, out_valid}, 4'd0);
        push(4'd4, 1'b1, 1'b0);
        finish_burst("b1", 4'd7, 1'b0, 4'd2);

        // 7 + 8 + 1 wraps to 0 with a sticky carry
        push(4'd7, 1'b0, 1'b0);
        push(4'd8, 1'b0, 1'b0);
        push(4'd1, 1'b1, 1'b0);
        finish_burst("b2", 4'd0, 1'b1, 4'd3);

        // 15, 5 (cout=1, acc=4), 0 with cin=1 -> 5
        push(4'd15, 1'b0, 1'b1);
        push(4'd5,  1'b0, 1'b1);
        push(4'd0,  1'b1, 1'b1);
        finish_burst("b3", 4'd5, 1'b1, 4'd3);

        // Cap at 8 operands, 9th stalls, result held under backpressure
        for (int i = 0; i < 8; i++) push(4'd1, 1'b0, 1'b0);
        chk("cap_in_ready", {3'b0, in_ready}, 4'd0);
        in_valid = 1'b1;
        in_data  = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {3'b0, out_valid}, 4'd1);
            chk("bp_sum",       out_sum,           4'd8);
            chk("bp_count",     out_count,         4'd8);
            chk("bp_in_ready",  {3'b0, in_ready},  4'd0);
        end
        in_valid = 1'b0;
        finish_burst("cap", 4'd8, 1'b0, 4'd8);

        // Mid-burst reset discards the partial result
        push(4'd5, 1'b0, 1'b0);
        push(4'd6, 1'b0, 1'b0);
        chk("pre_rst_sum", out_sum, 4'd11);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {3'b0, out_valid}, 4'd0);
        chk("midrst_sum",       out_sum,           4'd0);
        chk("midrst_count",     out_count,         4'd0);
        chk("midrst_in_ready",  {3'b0, in_ready},  4'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(4'd2, 1'b1, 1'b0);
        finish_burst("b5", 4'd2, 1'b0, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
